// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg : shared encodings for the matrix keypad reader           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package keypad_pkg;

  localparam int EVT_PRESS_BIT = 7;
  localparam int NOT_EMPTY     = 0;
  localparam int FULL          = 1;
  localparam int OVERFLOW      = 2;

  // Key state is 5 bits: 0..15 is a key index, bit 4 set means no key.
  localparam int              KEY_W    = 5;
  localparam logic [KEY_W-1:0] KEY_NONE = 5'h10;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    EVAL = 1'b1
  } scan_state_t;

  function automatic logic [7:0] keyEvent(input logic isPress, input logic [3:0] keyIdx);
    logic [7:0] evt;
    evt                = 8'h00;
    evt[EVT_PRESS_BIT] = isPress;
    evt[3:0]           = keyIdx;
    return evt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_reader_if : CPU read-side bus of the keypad peripheral        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface keypad_reader_if;
  logic       iDoKeypadRead;
  logic       iRegSel;
  logic [7:0] oKeypadReadData;

  modport master (output iDoKeypadRead, output iRegSel, input  oKeypadReadData);
  modport slave  (input  iDoKeypadRead, input  iRegSel, output oKeypadReadData);
endinterface
`default_nettype wire

// File: rtl/keypad_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_fifo : synchronous FIFO, head valid while not empty           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module keypad_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             iCpuClock,
  input  wire logic             iCpuReset,
  input  wire logic             iPush,
  input  wire logic [WIDTH-1:0] iPushData,
  input  wire logic             iPop,
  output logic      [WIDTH-1:0] oHead,
  output logic                  oFull,
  output logic                  oEmpty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPop;
  logic             w_doPush;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_doPop  = iPop & ~oEmpty;
  assign w_doPush = iPush & (~oFull | w_doPop);
  assign oFull    = (r_count == (AW+1)'(DEPTH));
  assign oEmpty   = (r_count == '0);
  assign oHead    = r_mem[r_rdPtr];

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge iCpuClock) begin
    if (w_doPush) r_mem[r_wrPtr] <= iPushData;
  end

endmodule
`default_nettype wire

// File: rtl/keypad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_reader : 4x4 keypad scanner, debouncer and event FIFO         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module keypad_reader #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  wire logic       iCpuClock,
  input  wire logic       iCpuReset,
  keypad_reader_if.slave  bus,
  output logic      [3:0] oKeypadRow,
  input  wire logic [3:0] iKeypadCol
);
  import keypad_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]       r_colMeta, r_colSync;
  scan_state_t      r_state;
  logic [1:0]       r_row;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_sweep;
  logic [KEY_W-1:0] r_stable, r_cand;
  logic [CNT_W-1:0] r_count;
  logic             r_push, r_pend, r_overflow;
  logic [7:0]       r_pushData, r_pendData;

  logic [4:0]       w_pressCount;
  logic [3:0]       w_pressIdx;
  logic [KEY_W-1:0] w_result, w_nextCand;
  logic [CNT_W-1:0] w_nextCount;
  logic             w_accept, w_twoEvents;
  logic [7:0]       w_firstEvt;
  logic [7:0]       w_head, w_status;
  logic             w_full, w_empty, w_pop, w_drop, w_statRead;

  assign oKeypadRow = ~(4'b0001 << r_row);

  // Sweep bits are active-low; bit index equals row*4+col, i.e. the key index.
  always_comb begin
    w_pressCount = '0;
    w_pressIdx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (!r_sweep[i]) begin
        w_pressCount = w_pressCount + 5'd1;
        w_pressIdx   = 4'(i);
      end
    end
    if (w_pressCount == 5'd0)      w_result = KEY_NONE;
    else if (w_pressCount == 5'd1) w_result = {1'b0, w_pressIdx};
    else                           w_result = r_stable;

    if (w_result == r_cand) begin
      w_nextCand  = r_cand;
      w_nextCount = (r_count == c_CNT_MAX) ? r_count : r_count + 1'b1;
    end else begin
      w_nextCand  = w_result;
      w_nextCount = CNT_W'(1);
    end
    w_accept    = (w_nextCount == c_CNT_MAX) && (w_nextCand != r_stable);
    w_twoEvents = (r_stable != KEY_NONE) && (w_nextCand != KEY_NONE);
    w_firstEvt  = (r_stable == KEY_NONE) ? keyEvent(1'b1, w_nextCand[3:0])
                                         : keyEvent(1'b0, r_stable[3:0]);
  end

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      r_colMeta  <= 4'hF;
      r_colSync  <= 4'hF;
      r_state    <= SCAN;
      r_row      <= '0;
      r_div      <= '0;
      r_sweep    <= '0;
      r_stable   <= KEY_NONE;
      r_cand     <= KEY_NONE;
      r_count    <= '0;
      r_push     <= 1'b0;
      r_pushData <= 8'h00;
      r_pend     <= 1'b0;
      r_pendData <= 8'h00;
    end else begin
      r_colMeta <= iKeypadCol;
      r_colSync <= r_colMeta;
      r_push    <= 1'b0;
      if (r_pend) begin
        r_push     <= 1'b1;
        r_pushData <= r_pendData;
        r_pend     <= 1'b0;
      end
      case (r_state)
        SCAN: begin
          if (r_div == c_DIV_LAST) begin
            r_div                       <= '0;
            r_sweep[{r_row, 2'b00} +: 4] <= r_colSync;
            r_row                       <= r_row + 1'b1;
            if (r_row == 2'd3) r_state <= EVAL;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        EVAL: begin
          r_cand  <= w_nextCand;
          r_count <= w_nextCount;
          r_state <= SCAN;
          // A key-to-key change queues the press behind the release.
          if (w_accept) begin
            r_stable   <= w_nextCand;
            r_push     <= 1'b1;
            r_pushData <= w_firstEvt;
            r_pend     <= w_twoEvents;
            r_pendData <= keyEvent(1'b1, w_nextCand[3:0]);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  keypad_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iCpuClock (iCpuClock),
    .iCpuReset (iCpuReset),
    .iPush     (r_push),
    .iPushData (r_pushData),
    .iPop      (w_pop),
    .oHead     (w_head),
    .oFull     (w_full),
    .oEmpty    (w_empty)
  );

  assign w_pop      = bus.iDoKeypadRead & ~bus.iRegSel & ~w_empty;
  assign w_drop     = r_push & w_full & ~w_pop;
  assign w_statRead = bus.iDoKeypadRead & bus.iRegSel;

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) r_overflow <= 1'b0;
    else           r_overflow <= w_drop | (r_overflow & ~w_statRead);
  end

  always_comb begin
    w_status            = 8'h00;
    w_status[NOT_EMPTY] = ~w_empty;
    w_status[FULL]      = w_full;
    w_status[OVERFLOW]  = r_overflow;
    bus.oKeypadReadData = 8'h00;
    if (bus.iDoKeypadRead) begin
      if (bus.iRegSel)  bus.oKeypadReadData = w_status;
      else if (!w_empty) bus.oKeypadReadData = w_head;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_reader : keypad matrix model plus sweep-level event model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_keypad_reader;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int DEPTH    = 4;
  localparam int SWEEP    = 4 * SCAN_DIV + 1;

  logic        cpuClock = 1'b0;
  logic        cpuReset;
  logic [3:0]  keypadRow;
  logic [3:0]  keypadCol;
  logic [15:0] held;
  logic [15:0] heldPrev;

  int errors = 0;
  int checks = 0;

  // Reference: key state per completed sweep, 16 means no key.
  int         mStable = 16;
  int         mCand   = 16;
  int         mCnt    = 0;
  bit         mOvf    = 1'b0;
  logic [7:0] mQ[$];

  always #5 cpuClock = ~cpuClock;

  keypad_reader_if bus();

  keypad_reader #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .iCpuClock  (cpuClock),
    .iCpuReset  (cpuReset),
    .bus        (bus),
    .oKeypadRow (keypadRow),
    .iKeypadCol (keypadCol)
  );

  // Passive matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    keypadCol = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!keypadRow[r]) keypadCol = keypadCol & ~held[r*4 +: 4];
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void modelPush(input logic [7:0] ev);
    if (mQ.size() >= DEPTH) mOvf = 1'b1;
    else                    mQ.push_back(ev);
  endfunction

  function automatic void modelSweep(input logic [15:0] h);
    int n = $countones(h);
    int r = mStable;
    if (n == 0) r = 16;
    else if (n == 1) for (int k = 0; k < 16; k++) if (h[k]) r = k;
    if (r == mCand) begin
      if (mCnt < DB) mCnt++;
    end else begin
      mCand = r;
      mCnt  = 1;
    end
    if (mCnt == DB && mCand != mStable) begin
      if (mStable != 16) modelPush(8'(mStable));
      if (mCand != 16)   modelPush(8'h80 | 8'(mCand));
      mStable = mCand;
    end
  endfunction

  task automatic waitBoundary();
    logic [3:0] last = keypadRow;
    bit found = 1'b0;
    for (int i = 0; i < 3 * SWEEP && !found; i++) begin
      @(negedge cpuClock);
      if (keypadRow == 4'b1110 && last == 4'b0111) found = 1'b1;
      last = keypadRow;
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL sweep_end: observed none expected one within %0d cycles", 3 * SWEEP);
    end
  endtask

  // Ends a sweep, applies the keys for the next one, then lets pushes land.
  task automatic sweep(input logic [15:0] nextHeld);
    waitBoundary();
    held = nextHeld;
    modelSweep(heldPrev);
    heldPrev = nextHeld;
    repeat (4) @(negedge cpuClock);
  endtask

  task automatic holdFor(input logic [15:0] pat, input int n);
    repeat (n) sweep(pat);
  endtask

  task automatic readReg(input logic sel, input string tag);
    logic [7:0] exp;
    bus.iDoKeypadRead = 1'b1;
    bus.iRegSel       = sel;
    if (sel) begin
      exp  = {5'b0, mOvf, mQ.size() == DEPTH, mQ.size() != 0};
      mOvf = 1'b0;
    end else begin
      exp = (mQ.size() != 0) ? mQ.pop_front() : 8'h00;
    end
    #1 check(tag, bus.oKeypadReadData, exp);
    @(negedge cpuClock);
    bus.iDoKeypadRead = 1'b0;
    bus.iRegSel       = 1'b0;
  endtask

  initial begin
    logic [3:0]  rowExp;
    logic [15:0] pat;
    cpuReset          = 1'b1;
    held              = '0;
    heldPrev          = '0;
    bus.iDoKeypadRead = 1'b0;
    bus.iRegSel       = 1'b0;
    repeat (3) @(negedge cpuClock);
    check("row_in_reset", {4'b0, keypadRow}, 8'h0E);
    cpuReset = 1'b0;

    for (int k = 0; k < 16; k++) begin
      rowExp = ~(4'b0001 << (k / 4));
      check("row_rotate", {4'b0, keypadRow}, {4'b0, rowExp});
      if (k == 0) begin
        bus.iDoKeypadRead = 1'b1;
        bus.iRegSel       = 1'b1;
        #1 check("status_reset", bus.oKeypadReadData, 8'h00);
        bus.iDoKeypadRead = 1'b0;
        bus.iRegSel       = 1'b0;
        check("data_idle", bus.oKeypadReadData, 8'h00);
      end
      if (k < 15) @(negedge cpuClock);
    end

    // Key 9 (row 2, col 1): press then release
    holdFor(16'h0200, 3);
    holdFor(16'h0000, 3);
    readReg(1'b0, "key9_press");
    readReg(1'b0, "key9_release");
    readReg(1'b0, "empty_data");

    // One-sweep glitch on key 5
    holdFor(16'h0020, 1);
    holdFor(16'h0000, 3);
    readReg(1'b1, "glitch_status");

    // Six press/release pairs without reads overflow the FIFO
    for (int p = 0; p < 6; p++) begin
      holdFor(16'(1) << (2 * p + 1), 2);
      holdFor(16'h0000, 2);
    end
    holdFor(16'h0000, 1);
    readReg(1'b1, "ovf_status");
    readReg(1'b1, "ovf_cleared");
    for (int i = 0; i < 4; i++) readReg(1'b0, "ovf_data");

    // Two keys together are ignored; then 3, then directly 12
    holdFor(16'h1008, 3);
    holdFor(16'h0000, 2);
    readReg(1'b1, "dual_status");
    holdFor(16'h0008, 3);
    holdFor(16'h1000, 3);
    readReg(1'b0, "k3_press");
    readReg(1'b0, "k3_release");
    readReg(1'b0, "k12_press");
    holdFor(16'h0000, 3);
    readReg(1'b0, "k12_release");

    // Randomized keys and reads
    for (int it = 0; it < 40; it++) begin
      int choice = $urandom_range(0, 99);
      int a = $urandom_range(0, 15);
      int b = $urandom_range(0, 15);
      int nr;
      if (choice < 35)      pat = 16'h0000;
      else if (choice < 85) pat = 16'(1) << a;
      else                  pat = (16'(1) << a) | (16'(1) << b);
      holdFor(pat, $urandom_range(1, 3));
      nr = $urandom_range(0, 3);
      for (int r = 0; r < nr; r++) readReg(1'($urandom_range(0, 1)), "rand_read");
    end

    // Settle, drain, then load two events and reset mid-sweep
    holdFor(16'h0000, 3);
    readReg(1'b1, "drain_status");
    while (mQ.size() != 0) readReg(1'b0, "drain_data");
    holdFor(16'h0080, 3);
    holdFor(16'h0000, 3);
    readReg(1'b1, "two_held");
    repeat (6) @(negedge cpuClock);
    cpuReset = 1'b1;
    #1 check("row_after_rst", {4'b0, keypadRow}, 8'h0E);
    bus.iDoKeypadRead = 1'b1;
    bus.iRegSel       = 1'b0;
    #1 check("data_in_rst", bus.oKeypadReadData, 8'h00);
    bus.iDoKeypadRead = 1'b0;
    mQ.delete();
    mOvf    = 1'b0;
    mStable = 16;
    mCand   = 16;
    mCnt    = 0;
    @(negedge cpuClock);
    cpuReset = 1'b0;
    check("row_post_rst", {4'b0, keypadRow}, 8'h0E);
    readReg(1'b1, "status_post_rst");
    readReg(1'b0, "data_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
